// File: rtl/frame_sequencer_if.sv
// Pixel-scheduler bus: run request in, memory address and driver strobes out.
interface frame_sequencer_if #(
   parameter int NUM_PIXELS = 64,
   parameter int NUM_FRAMES = 10
);
   localparam int PIXEL_W = $clog2(NUM_PIXELS);
   localparam int FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

   logic               enable;
   logic [PIXEL_W-1:0] pixel;
   logic [FRAME_W-1:0] frame;
   logic               load_sreg;
   logic               transmit_pixel;
   logic               frame_start;
   logic               busy;

   // Sequencer side.
   modport master (
      input  enable,
      output pixel,
      output frame,
      output load_sreg,
      output transmit_pixel,
      output frame_start,
      output busy
   );

   // Controller / datapath side.
   modport slave (
      output enable,
      input  pixel,
      input  frame,
      input  load_sreg,
      input  transmit_pixel,
      input  frame_start,
      input  busy
   );
endinterface

// File: rtl/frame_sequencer.sv
// LED-matrix refresh scheduler: walks pixels of the current frame, pulses the
// shift-register load, holds transmit for a fixed bit budget, inserts the
// latch gap and advances through the stored animation.
module frame_sequencer #(
   parameter int NUM_PIXELS       = 64,
   parameter int NUM_FRAMES       = 10,
   parameter int CYCLES_PER_PIXEL = 360,
   parameter int LATCH_CYCLES     = 1200,
   parameter int FRAME_REPEAT     = 12
) (
   input  logic                clk,
   input  logic                rst,
   frame_sequencer_if.master   seq
);
   localparam int PIXEL_W = $clog2(NUM_PIXELS);
   localparam int FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
   localparam int RPT_W   = (FRAME_REPEAT > 1) ? $clog2(FRAME_REPEAT) : 1;
   localparam int CNT_MAX = (CYCLES_PER_PIXEL > LATCH_CYCLES) ? CYCLES_PER_PIXEL : LATCH_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [PIXEL_W-1:0] LAST_PIXEL = PIXEL_W'(NUM_PIXELS - 1);
   localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
   localparam logic [RPT_W-1:0]   LAST_RPT   = RPT_W'(FRAME_REPEAT - 1);
   localparam logic [CNT_W-1:0]   TX_LOAD    = CNT_W'(CYCLES_PER_PIXEL - 1);
   localparam logic [CNT_W-1:0]   LATCH_LOAD = CNT_W'(LATCH_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      TX,
      LATCH
   } state_t;

   state_t             state_q, state_d;
   logic [PIXEL_W-1:0] pixel_q, pixel_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic [RPT_W-1:0]   rpt_q,   rpt_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;

   // State and datapath registers; reset returns to frame 0, pixel 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pixel_q <= '0;
         frame_q <= '0;
         rpt_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pixel_q <= pixel_d;
         frame_q <= frame_d;
         rpt_q   <= rpt_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state, address and counter updates; values hold unless a state boundary moves them.
   always_comb begin
      state_d = state_q;
      pixel_d = pixel_q;
      frame_d = frame_q;
      rpt_d   = rpt_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (seq.enable) state_d = FETCH;
         end
         FETCH: begin
            state_d = LOAD;
         end
         LOAD: begin
            state_d = TX;
            cnt_d   = TX_LOAD;
         end
         TX: begin
            if (cnt_q == '0) begin
               if (pixel_q == LAST_PIXEL) begin
                  state_d = LATCH;
                  pixel_d = '0;
                  cnt_d   = LATCH_LOAD;
               end else begin
                  state_d = FETCH;
                  pixel_d = pixel_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         LATCH: begin
            if (cnt_q == '0) begin
               if (rpt_q == LAST_RPT) begin
                  rpt_d   = '0;
                  frame_d = (frame_q == LAST_FRAME) ? '0 : frame_q + 1'b1;
               end else begin
                  rpt_d = rpt_q + 1'b1;
               end
               state_d = seq.enable ? FETCH : IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Strobes decode straight from state so reset drops them without waiting for a clock.
   always_comb begin
      seq.load_sreg      = (state_q == LOAD);
      seq.transmit_pixel = (state_q == TX);
      seq.busy           = (state_q != IDLE);
      // pixel is only 0 in FETCH on the first pixel of a refresh
      seq.frame_start    = (state_q == FETCH) && (pixel_q == '0);
   end

   assign seq.pixel = pixel_q;
   assign seq.frame = frame_q;
endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer at 4 pixels, 3 frames, 5 cycles/pixel,
// 8-cycle latch, 2 repeats (36-cycle refresh).
module tb_frame_sequencer;
   localparam int NP  = 4;
   localparam int NF  = 3;
   localparam int CPP = 5;
   localparam int LC  = 8;
   localparam int FR  = 2;

   logic clk;
   logic rst;

   frame_sequencer_if #(.NUM_PIXELS(NP), .NUM_FRAMES(NF)) bus ();

   frame_sequencer #(
      .NUM_PIXELS      (NP),
      .NUM_FRAMES      (NF),
      .CYCLES_PER_PIXEL(CPP),
      .LATCH_CYCLES    (LC),
      .FRAME_REPEAT    (FR)
   ) dut (
      .clk(clk),
      .rst(rst),
      .seq(bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, " pixel"},          32'(bus.pixel), 0);
      check({tag, " frame"},          32'(bus.frame), 0);
      check({tag, " load_sreg"},      32'(bus.load_sreg), 0);
      check({tag, " transmit_pixel"}, 32'(bus.transmit_pixel), 0);
      check({tag, " frame_start"},    32'(bus.frame_start), 0);
      check({tag, " busy"},           32'(bus.busy), 0);
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      bus.enable = 1'($urandom_range(0, 1));
      tick();
      check_zero("rst_hold1");
      bus.enable = 1'($urandom_range(0, 1));
      tick();
      check_zero("rst_hold2");
      rst        = 1'b0;
      bus.enable = 1'b0;
      tick();
      check_zero("rst_post");
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int k;
      k = 0;
      while (bus.busy && k < budget) begin
         tick();
         k++;
      end
      check({tag, " idle"}, 32'(bus.busy), 0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int exp_fr[8];
      exp_fr = '{0, 0, 1, 1, 2, 2, 0, 0};
      rst        = 1'b1;
      bus.enable = 1'b0;

      // 1. reset values
      do_reset();

      // 2. single refresh
      begin
         int fs, nl, nw, run, gap, idle_at;
         int load_at[4];
         int load_px[4];
         int win[4];
         fs = 0; nl = 0; nw = 0; run = 0; gap = 0; idle_at = -1;
         bus.enable = 1'b1;
         tick();
         bus.enable = 1'b0;
         for (int i = 0; i < 40; i++) begin
            if (i > 0) tick();
            if (bus.frame_start) fs++;
            if (bus.load_sreg) begin
               if (nl < 4) begin
                  load_at[nl] = i;
                  load_px[nl] = 32'(bus.pixel);
               end
               nl++;
            end
            if (bus.transmit_pixel) run++;
            else if (run > 0) begin
               if (nw < 4) win[nw] = run;
               nw++;
               run = 0;
            end
            if (nw == 4 && bus.busy && !bus.transmit_pixel && !bus.load_sreg) gap++;
            if (!bus.busy && idle_at < 0) idle_at = i;
         end
         check("single frame_start count", 32'(fs), 1);
         check("single load count", 32'(nl), 4);
         check("single window count", 32'(nw), 4);
         check("single first load", 32'(load_at[0]), 1);
         for (int k = 0; k < 4 && k < nl; k++) begin
            check("single load pixel", 32'(load_px[k]), 32'(k));
            if (k > 0) check("single load spacing", 32'(load_at[k] - load_at[k-1]), 7);
         end
         for (int k = 0; k < 4 && k < nw; k++)
            check("single tx window", 32'(win[k]), CPP);
         check("single latch gap", 32'(gap), LC);
         check("single idle cycle", 32'(idle_at), 36);
         check("single end busy", 32'(bus.busy), 0);
         check("single end pixel", 32'(bus.pixel), 0);
         check("single end frame", 32'(bus.frame), 0);
      end

      // 3. continuous run
      do_reset();
      begin
         int fs_at[8];
         int fs_fr[8];
         int n;
         n = 0;
         bus.enable = 1'b1;
         tick();
         for (int i = 0; i < 8 * 36 + 10 && n < 8; i++) begin
            if (i > 0) tick();
            if (bus.frame_start) begin
               fs_at[n] = i;
               fs_fr[n] = 32'(bus.frame);
               n++;
            end
         end
         check("cont pulse count", 32'(n), 8);
         for (int k = 0; k < n; k++) begin
            check("cont frame at start", 32'(fs_fr[k]), 32'(exp_fr[k]));
            if (k > 0) check("cont refresh period", 32'(fs_at[k] - fs_at[k-1]), 36);
         end
         bus.enable = 1'b0;
         wait_idle("cont", 60);
      end

      // 4. late disable
      do_reset();
      begin
         int nl, ntx, idle_at;
         nl = 0; ntx = 0; idle_at = -1;
         bus.enable = 1'b1;
         tick();
         for (int i = 0; i < 60 && idle_at < 0; i++) begin
            if (i > 0) tick();
            if (i == 10) begin
               check("late in tx pixel1 pixel", 32'(bus.pixel), 1);
               check("late in tx pixel1 tx", 32'(bus.transmit_pixel), 1);
               bus.enable = 1'b0;
            end
            if (bus.load_sreg) nl++;
            if (bus.transmit_pixel) ntx++;
            if (!bus.busy) idle_at = i;
         end
         check("late load count", 32'(nl), 4);
         check("late tx cycles", 32'(ntx), 4 * CPP);
         check("late idle cycle", 32'(idle_at), 36);
         check("late frame after 1", 32'(bus.frame), 0);
         bus.enable = 1'b1;
         tick();
         check("late 2nd start", 32'(bus.frame_start), 1);
         bus.enable = 1'b0;
         wait_idle("late 2nd", 60);
         check("late frame after 2", 32'(bus.frame), 1);
      end

      // 5. mid-TX reset
      do_reset();
      begin
         int run;
         run = 0;
         bus.enable = 1'b1;
         tick();
         for (int i = 1; i <= 90; i++) tick();
         check("midrst pre frame", 32'(bus.frame), 1);
         check("midrst pre pixel", 32'(bus.pixel), 2);
         check("midrst pre tx", 32'(bus.transmit_pixel), 1);
         rst = 1'b1;
         #1;
         check("midrst tx drop", 32'(bus.transmit_pixel), 0);
         check("midrst busy", 32'(bus.busy), 0);
         check("midrst frame", 32'(bus.frame), 0);
         check("midrst pixel", 32'(bus.pixel), 0);
         tick();
         check("midrst held busy", 32'(bus.busy), 0);
         rst = 1'b0;
         tick();
         check("restart frame_start", 32'(bus.frame_start), 1);
         check("restart pixel", 32'(bus.pixel), 0);
         check("restart frame", 32'(bus.frame), 0);
         tick();
         check("restart load", 32'(bus.load_sreg), 1);
         for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.transmit_pixel) run++;
            else break;
         end
         check("restart tx window", 32'(run), CPP);
         bus.enable = 1'b0;
         wait_idle("restart", 60);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Scheduler for the LED-matrix pixel datapath. It walks the pixel memories one address at a time and pulses the shift-register load. It holds the serial driver's transmit enable for a fixed per-pixel bit budget. At the end of each refresh it inserts the WS2812B latch gap, then advances through a stored animation of `NUM_FRAMES` frames, showing each frame for `FRAME_REPEAT` refreshes. The top level forms the memory read address as `{frame, pixel}`.

## Interface
Parameters:
- `NUM_PIXELS`, default 64: pixels per frame; must be ≥ 2.
- `NUM_FRAMES`, default 10: frames in the animation; must be ≥ 1.
- `CYCLES_PER_PIXEL`, default 360: `transmit_pixel` high-time per pixel (24 bits × 15 clk).
- `LATCH_CYCLES`, default 1200: idle-low gap after the last pixel of a refresh; must be ≥ 1.
- `FRAME_REPEAT`, default 12: refreshes per frame before advancing; must be ≥ 1.

Ports:
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `enable`, input, 1: run request; level-sensitive.
- `pixel`, output, `$clog2(NUM_PIXELS)`: pixel index within the frame (memory read address low part).
- `frame`, output, `$clog2(NUM_FRAMES)` (minimum 1): current animation frame (address high part).
- `load_sreg`, output, 1: one-cycle pulse that loads the GRB shift register from the memory outputs.
- `transmit_pixel`, output, 1: enables the serial driver for the current pixel.
- `frame_start`, output, 1: one-cycle pulse on the first FETCH of every refresh.
- `busy`, output, 1: high in every state except IDLE.

## Operation
States: IDLE, FETCH, LOAD, TX, LATCH.

Transitions:
- IDLE → FETCH when `enable` = 1.
- FETCH → LOAD after 1 cycle. `pixel` is stable during FETCH; the memory has a 1-cycle read latency.
- LOAD → TX after 1 cycle. `load_sreg` = 1 only in LOAD.
- TX: `transmit_pixel` = 1 for exactly `CYCLES_PER_PIXEL` cycles, counted by a down-counter.
  - On the last TX cycle with `pixel` < `NUM_PIXELS`-1: `pixel` increments, next state FETCH.
  - On the last TX cycle with `pixel` = `NUM_PIXELS`-1: next state LATCH. `pixel` wraps to 0 on entry to LATCH.
- LATCH: all strobes low for `LATCH_CYCLES` cycles. On the last cycle:
  - The repeat counter increments.
  - When it reaches `FRAME_REPEAT`, the repeat counter clears and `frame` increments; `frame` wraps from `NUM_FRAMES`-1 to 0.
  - Next state is FETCH if `enable` = 1, otherwise IDLE.

Enable rules:
- `enable` is sampled only in IDLE and on the last LATCH cycle.
- Deasserting `enable` mid-refresh does not truncate the refresh; it completes, including the latch gap.
- The block never stops mid-pixel.

General rules:
- `frame` and `pixel` change only on state boundaries, never inside TX.
- Counter widths cover their terminal values without overflow; all counters are unsigned.

Reset (asynchronous, any state):
- State returns to IDLE.
- `pixel`, `frame`, the repeat counter and the cycle counter go to 0.
- All outputs go low; `pixel` and `frame` go to 0.
- After reset the next refresh starts at frame 0, pixel 0.
- If reset asserts mid-TX, `transmit_pixel` drops immediately. The downstream driver sees a truncated pixel; this is acceptable, because the latch gap of the following run re-synchronises the LEDs.

## Timing
- Latency from `enable` rising while in IDLE: FETCH is entered on the next edge, `load_sreg` follows 1 cycle later, and `transmit_pixel` rises the cycle after that.
- Per-pixel period: `2 + CYCLES_PER_PIXEL` cycles.
- Refresh period: `NUM_PIXELS·(2 + CYCLES_PER_PIXEL) + LATCH_CYCLES` cycles. At the defaults this is 64·362 + 1200 = 24368 cycles.
- `frame_start` is coincident with the first FETCH of the refresh.
- `transmit_pixel` is low for exactly 2 cycles (FETCH + LOAD) between consecutive pixels of a refresh.
- Frame period: `FRAME_REPEAT` × refresh period.

## Test plan
All scenarios use `NUM_PIXELS`=4, `NUM_FRAMES`=3, `CYCLES_PER_PIXEL`=5, `LATCH_CYCLES`=8, `FRAME_REPEAT`=2, giving a refresh period of 36 cycles.

1. **Reset values.** Assert `rst` with random `enable` → every output reads 0 while `rst` is high and on the first cycle after release with `enable`=0.
2. **Single refresh.** Raise `enable` once, then drop it after 1 cycle → the following are produced, then IDLE with `busy`=0:
   - `frame_start` pulses once.
   - `load_sreg` pulses 4 times, 7 cycles apart.
   - Each `transmit_pixel` window is exactly 5 cycles; `pixel` reads 0, 1, 2, 3 at the respective `load_sreg` pulses.
   - The latch gap is 8 low cycles.
3. **Continuous run.** Hold `enable`=1 for 8 refreshes → `frame_start` pulses are 36 cycles apart, and `frame` at successive `frame_start` pulses reads 0, 0, 1, 1, 2, 2, 0, 0.
4. **Late disable.** Drop `enable` during the TX of pixel 1 → the refresh completes all 4 pixels plus the 8-cycle latch gap, then the block idles; `frame` and the repeat counter are updated by that refresh.
5. **Mid-TX reset.** Assert `rst` mid-TX of pixel 2 in frame 1 → `transmit_pixel` drops in the same cycle; on restart `frame`=0, `pixel`=0, and the first `transmit_pixel` window is a full 5 cycles.
